// File: rtl/key_accumulator_pkg.sv
// Shared types for the per-key accumulator: FSM encoding and the stage-1 pipeline register.
// Stage-1 fields are sized for the widest supported configuration; users cast down to their widths.
package accum_pkg;

  localparam int unsigned KEY_MAX = 16;
  localparam int unsigned SUM_MAX = 64;

  typedef enum logic [2:0] {
    INIT,
    ACCUM,
    DRAIN,
    FLUSH_RD,
    FLUSH_CAP,
    FLUSH_OUT
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [KEY_MAX-1:0] key;
    logic [SUM_MAX-1:0] val;
  } stage1_t;

endpackage

// File: rtl/key_accumulator_ram.sv
// Simple dual-port RAM (one write, one read port), one-cycle registered read.
// Optional write-to-read bypass so a read issued in the same cycle as a write to that address returns the new data.
module key_accumulator_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter     STYLE      = "block",
  parameter bit HAS_BYPASS = 1'b1,
  parameter bit HAS_CACHE  = 1'b0
) (
  input  logic                  clk,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0] fwd_q;
  logic                  fwd_vld_q;
  logic                  cache_vld_q;
  logic [ADDR_WIDTH-1:0] cache_addr_q;
  logic [DATA_WIDTH-1:0] cache_dat_q;
  logic                  fwd_hit;
  logic                  cache_hit;

  if (STYLE == "ultra") begin : g_ultra
    (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (write_enable) mem[write_addr] <= write_data;
      mem_q <= mem[read_addr];
    end
  end else begin : g_block
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (write_enable) mem[write_addr] <= write_data;
      mem_q <= mem[read_addr];
    end
  end

  // One-entry cache of the last write, for macros whose write lands a cycle late.
  always_ff @(posedge clk) begin
    if (write_enable) begin
      cache_vld_q  <= 1'b1;
      cache_addr_q <= write_addr;
      cache_dat_q  <= write_data;
    end
  end

  assign fwd_hit   = HAS_BYPASS && write_enable && (write_addr == read_addr);
  assign cache_hit = HAS_CACHE && cache_vld_q && (cache_addr_q == read_addr);

  always_ff @(posedge clk) begin
    fwd_vld_q <= fwd_hit || cache_hit;
    fwd_q     <= fwd_hit ? write_data : cache_dat_q;
  end

  assign read_data = fwd_vld_q ? fwd_q : mem_q;

endmodule

// File: rtl/key_accumulator.sv
// Per-key RMW accumulator: 1 beat/cycle in ACCUM, flush streams (key,sum) in key order, >=3 cycles/entry.
// in_ready drops from flush until the last output handshake; output beat held while out_ready is low.
module key_accumulator
  import accum_pkg::*;
#(
  parameter int KEY_WIDTH = 8,
  parameter int VAL_WIDTH = 16,
  parameter int SUM_WIDTH = 32,
  parameter     STYLE     = "block"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [KEY_WIDTH-1:0] in_key,
  input  logic [VAL_WIDTH-1:0] in_val,
  input  logic                 flush_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [KEY_WIDTH-1:0] out_key,
  output logic [SUM_WIDTH-1:0] out_sum,
  output logic                 out_last,
  output logic                 busy
);

  localparam logic [KEY_WIDTH-1:0] LAST_IDX = '1;

  state_t                 state_q, state_d;
  logic [KEY_WIDTH-1:0]   idx_q, idx_d;
  stage1_t                st_q, st_d;
  logic [KEY_WIDTH-1:0]   out_key_q;
  logic [SUM_WIDTH-1:0]   out_sum_q;
  logic                   cap;

  logic                   write_enable;
  logic [KEY_WIDTH-1:0]   write_addr;
  logic [SUM_WIDTH-1:0]   write_data;
  logic [KEY_WIDTH-1:0]   read_addr;
  logic [SUM_WIDTH-1:0]   read_data;

  key_accumulator_ram #(
    .DATA_WIDTH (SUM_WIDTH),
    .ADDR_WIDTH (KEY_WIDTH),
    .STYLE      (STYLE),
    .HAS_BYPASS (1'b1),
    .HAS_CACHE  (1'b0)
  ) u_ram (
    .clk          (clk),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_addr    (read_addr),
    .read_data    (read_data)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    st_d         = '0;
    cap          = 1'b0;
    in_ready     = 1'b0;
    read_addr    = idx_q;
    write_enable = 1'b0;
    write_addr   = idx_q;
    write_data   = '0;

    // Stage 1 is only ever occupied in ACCUM/DRAIN, so it never contends with idx writes.
    if (st_q.valid) begin
      write_enable = 1'b1;
      write_addr   = KEY_WIDTH'(st_q.key);
      write_data   = SUM_WIDTH'(SUM_MAX'(read_data) + st_q.val);
    end

    case (state_q)
      INIT: begin
        write_enable = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ACCUM;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + KEY_WIDTH'(1);
        end
      end
      ACCUM: begin
        in_ready     = 1'b1;
        read_addr    = in_key;
        st_d.valid   = in_valid;
        st_d.key     = KEY_MAX'(in_key);
        st_d.val     = SUM_MAX'(in_val);
        if (flush_req) state_d = DRAIN;
      end
      DRAIN: begin
        idx_d   = '0;
        state_d = FLUSH_RD;
      end
      FLUSH_RD: begin
        state_d = FLUSH_CAP;
      end
      FLUSH_CAP: begin
        cap          = 1'b1;
        write_enable = 1'b1;
        state_d      = FLUSH_OUT;
      end
      FLUSH_OUT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ACCUM;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + KEY_WIDTH'(1);
            state_d = FLUSH_RD;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= INIT;
      idx_q     <= '0;
      st_q      <= '0;
      out_key_q <= '0;
      out_sum_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
      if (cap) begin
        out_key_q <= idx_q;
        out_sum_q <= read_data;
      end
    end
  end

  assign out_valid = (state_q == FLUSH_OUT);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_key   = out_key_q;
  assign out_sum   = out_sum_q;
  assign busy      = !((state_q == ACCUM) && !st_q.valid);

endmodule
